// File: rtl/sqrt_operand_sequencer.sv
// Feeds buffered operands to Int_SQRT_Calculator one at a time and returns {x, root}.
// Optional result self-check enabled by defining SQRT_CHECK_EN.
module sqrt_operand_sequencer #(
    parameter int WIDTH       = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int WAIT_CYCLES = 20
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             S,
    output logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] sqrt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_root,
    output logic             busy,
    output logic             err,
    output logic [7:0]       err_count,
    output logic [1:0]       dbg_state
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, OUT} state_t;

    state_t          state, state_next;
    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic [CW-1:0]   cnt;
    logic            push, pop, run_done;

    // Both ports: a transfer happens on a rising edge where valid && ready;
    // the sender holds data stable while valid is high and ready is low.
    assign in_ready  = (count != (AW+1)'(FIFO_DEPTH));
    assign push      = in_valid && in_ready;
    assign pop       = (state == IDLE) && (count != '0);
    assign run_done  = (cnt == CW'(WAIT_CYCLES - 1));
    assign busy      = (state != IDLE) || (count != '0);
    assign dbg_state = state;

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (count != '0) state_next = LOAD;
            LOAD:    state_next = RUN;
            RUN:     if (run_done) state_next = OUT;
            OUT:     if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // X is loaded a cycle before S rises so the calculator sees a settled operand.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            X         <= '0;
            S         <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_x     <= '0;
            out_root  <= '0;
        end else begin
            case (state)
                IDLE: if (pop) X <= mem[rd_ptr];
                LOAD: begin
                    S   <= 1'b1;
                    cnt <= '0;
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (run_done) begin
                        out_root  <= sqrt;
                        out_x     <= X;
                        out_valid <= 1'b1;
                        S         <= 1'b0;
                    end
                end
                OUT: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef SQRT_CHECK_EN
    logic [WIDTH:0]     r1;
    logic [2*WIDTH+1:0] r_sq, r1_sq, x_ext;
    logic               bad;

    // Widened so (r+1)^2 cannot wrap at r = 2^WIDTH-1.
    always_comb begin
        r1    = {1'b0, sqrt} + 1'b1;
        x_ext = (2*WIDTH+2)'(X);
        r_sq  = (2*WIDTH+2)'(sqrt) * (2*WIDTH+2)'(sqrt);
        r1_sq = (2*WIDTH+2)'(r1) * (2*WIDTH+2)'(r1);
        bad   = !((r_sq <= x_ext) && (r1_sq > x_ext));
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            err       <= 1'b0;
            err_count <= '0;
        end else if ((state == RUN) && run_done) begin
            err <= bad;
            if (bad && (err_count != 8'hFF)) err_count <= err_count + 1'b1;
        end
    end
`else
    assign err       = 1'b0;
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_sqrt_operand_sequencer.sv
// Directed self-checking bench for sqrt_operand_sequencer with a behavioural calculator model.
module tb_sqrt_operand_sequencer;
    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       S;
    logic [7:0] X;
    logic [7:0] sqrt;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_x, out_root;
    logic       busy, err;
    logic [7:0] err_count;
    logic [1:0] dbg_state;

    logic       ovr_en = 1'b0;
    logic [7:0] ovr_val = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int n_res = 0;
    logic [16:0] exp_q[$];
    logic [16:0] e;

    always #10 CLK = ~CLK;

    sqrt_operand_sequencer dut (
        .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .S(S), .X(X), .sqrt(sqrt), .out_valid(out_valid),
        .out_ready(out_ready), .out_x(out_x), .out_root(out_root), .busy(busy),
        .err(err), .err_count(err_count), .dbg_state(dbg_state)
    );

    function automatic int floor_sqrt(input int x);
        int r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    assign sqrt = ovr_en ? ovr_val : 8'(floor_sqrt(int'(X)));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Scoreboard: every out handshake must match the head of exp_q.
    always @(negedge CLK) begin
        if (RESET && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_x", 32'(out_x), 32'(e[15:8]));
                check("out_root", 32'(out_root), 32'(e[7:0]));
                check("err", 32'(err), 32'(e[16]));
                n_res++;
            end
        end
    end

    // S pulse-width and gap statistics.
    logic stat_en = 1'b0;
    logic s_prev = 1'b0;
    logic seen_fall = 1'b0;
    int hi_run = 0, lo_run = 0;
    int hi_min = 999, hi_max = 0, lo_min = 999, lo_max = 0;
    always @(negedge CLK) begin
        if (stat_en) begin
            if (S) hi_run++;
            if (s_prev && !S) begin
                if (hi_run < hi_min) hi_min = hi_run;
                if (hi_run > hi_max) hi_max = hi_run;
                hi_run = 0;
                lo_run = 0;
                seen_fall = 1'b1;
            end
            if (!S && seen_fall) lo_run++;
            if (!s_prev && S && seen_fall) begin
                if (lo_run < lo_min) lo_min = lo_run;
                if (lo_run > lo_max) lo_max = lo_run;
            end
            s_prev = S;
        end else begin
            s_prev = 1'b0;
            seen_fall = 1'b0;
            hi_run = 0;
            lo_run = 0;
        end
    end

    task automatic push_one(input logic [7:0] x);
        int waited = 0;
        logic rdy;
        in_valid = 1'b1;
        in_data  = x;
        do begin
            rdy = in_ready;
            @(posedge CLK); #1;
            waited++;
        end while (!rdy && waited < 200);
        in_valid = 1'b0;
        check("push_accept", 32'(rdy), 32'd1);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy || out_valid) && n < budget) begin
            @(posedge CLK); #1;
            n++;
        end
        check("drain_timeout", 32'(n >= budget), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_S"}, 32'(S), 32'd0);
        check({tag, "_X"}, 32'(X), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_err_count"}, 32'(err_count), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s_hi, ov_edge, res0, ov_seen, s_seen;
        logic [7:0] d3 [6];
        logic [7:0] r3 [5];
        logic [5:0] rdy_hist;

        // Test 1: reset state
        #5;
        check_reset_outputs("rst");
        #40 RESET = 1'b1;
        @(posedge CLK); #1;

        // Test 2: single operand 200, timing and data
        out_ready = 1'b1;
        exp_q.push_back({1'b0, 8'd200, 8'd14});
        push_one(8'd200);
        s_hi = 0;
        ov_edge = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge CLK); #1;
            if (S) s_hi++;
            if (out_valid && ov_edge < 0) ov_edge = k;
            if (k == 10) begin
                check("t2_X_hold", 32'(X), 32'd200);
                check("t2_busy", 32'(busy), 32'd1);
            end
        end
        check("t2_s_high_cycles", 32'(s_hi), 32'd20);
        check("t2_out_valid_edge", 32'(ov_edge), 32'd22);
        check("t2_X_kept_idle", 32'(X), 32'd200);
        wait_drain(100);

        // Test 3: stalled output, FIFO fills, 6th offer refused
        out_ready = 1'b0;
        d3 = '{8'd9, 8'd100, 8'd255, 8'd0, 8'd64, 8'd77};
        r3 = '{8'd3, 8'd10, 8'd15, 8'd0, 8'd8};
        for (int i = 0; i < 5; i++) exp_q.push_back({1'b0, d3[i], r3[i]});
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = d3[i];
            @(posedge CLK); #1;
            rdy_hist[i] = in_ready;
        end
        in_valid = 1'b0;
        check("t3_in_ready_hist", 32'(rdy_hist), 32'h0F);
        repeat (45) begin
            @(posedge CLK); #1;
        end
        check("t3_stall_out_valid", 32'(out_valid), 32'd1);
        check("t3_stall_out_x", 32'(out_x), 32'd9);
        check("t3_stall_out_root", 32'(out_root), 32'd3);
        check("t3_stall_S", 32'(S), 32'd0);
        check("t3_stall_in_ready", 32'(in_ready), 32'd0);
        res0 = n_res;
        out_ready = 1'b1;
        wait_drain(400);
        check("t3_results", 32'(n_res - res0), 32'd5);
        repeat (40) begin
            @(posedge CLK); #1;
        end
        check("t3_idle_busy", 32'(busy), 32'd0);

        // Test 4: stream 1..255 through the floor-sqrt model
        res0 = n_res;
        stat_en = 1'b1;
        for (int x = 1; x <= 255; x++) begin
            exp_q.push_back({1'b0, 8'(x), 8'(floor_sqrt(x))});
            push_one(8'(x));
        end
        wait_drain(1000);
        stat_en = 1'b0;
        check("t4_results", 32'(n_res - res0), 32'd255);
        check("t4_s_high_min", 32'(hi_min), 32'd20);
        check("t4_s_high_max", 32'(hi_max), 32'd20);
        check("t4_s_gap_min", 32'(lo_min), 32'd3);
        check("t4_s_gap_max", 32'(lo_max), 32'd3);
        check("t4_err_count", 32'(err_count), 32'd0);

        // Test 5: asynchronous reset mid-run with two operands queued
        push_one(8'd50);
        push_one(8'd60);
        push_one(8'd70);
        s_seen = 0;
        while (!S && s_seen < 50) begin
            @(posedge CLK); #1;
            s_seen++;
        end
        check("t5_s_rose", 32'(S), 32'd1);
        repeat (9) @(posedge CLK);
        #5 RESET = 1'b0;
        #1;
        check_reset_outputs("t5");
        exp_q.delete();
        #30 RESET = 1'b1;
        @(posedge CLK); #1;
        ov_seen = 0;
        s_seen = 0;
        repeat (40) begin
            @(posedge CLK); #1;
            if (out_valid) ov_seen++;
            if (S) s_seen++;
        end
        check("t5_no_out_valid", 32'(ov_seen), 32'd0);
        check("t5_no_S", 32'(s_seen), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);

`ifdef SQRT_CHECK_EN
        // Test 6: wrong root flagged, then correct root clears err
        ovr_en  = 1'b1;
        ovr_val = 8'd15;
        exp_q.push_back({1'b1, 8'd200, 8'd15});
        push_one(8'd200);
        wait_drain(100);
        check("t6_err_count_1", 32'(err_count), 32'd1);
        ovr_val = 8'd14;
        exp_q.push_back({1'b0, 8'd200, 8'd14});
        push_one(8'd200);
        wait_drain(100);
        check("t6_err_count_hold", 32'(err_count), 32'd1);
        ovr_en = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
